mem_bus_arbiter: RTL

- Shares the single memory bus of cpu_core between two requesters: instruction fetch (I-port) and load/store data access (D-port).
- Latches one request at a time and drives address_out/data_out_BUS with a read or write strobe.
- Waits for the bus_full completion strobe, returns data_in_BUS to the winning requester, and acknowledges it.
- Bounds every bus transaction with a timeout, so a dead bus cannot hang the core.

---
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the cpu_core memory bus between the fetch port
// and the load/store port, with alternating priority and a bus timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              bus_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out_BUS,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [DATA_W-1:0] data_in_BUS,
  input  logic              bus_full
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic last_d_q, last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic i_ack_q, i_ack_d;
  logic d_ack_q, d_ack_d;
  logic err_q, err_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] aout_q, aout_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic d_pend;
  logic grant_d;
  logic grant_i;

  // On contention the port that did not win last time is served.
  assign d_pend  = d_read | d_write;
  assign grant_d = d_pend & (~i_req | ~last_d_q);
  assign grant_i = i_req & ~grant_d;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    aout_d    = '0;
    dout_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = D_WAIT;
          last_d_d = 1'b1;
          cnt_d    = '0;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_write;
          rd_d     = ~d_write;
          wr_d     = d_write;
          aout_d   = d_addr;
          dout_d   = d_write ? d_wdata : '0;
        end else if (grant_i) begin
          state_d  = I_WAIT;
          last_d_d = 1'b0;
          cnt_d    = '0;
          addr_d   = i_addr;
          we_d     = 1'b0;
          rd_d     = 1'b1;
          aout_d   = i_addr;
        end
      end
      I_WAIT, D_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_full) begin
          state_d = RESP;
          i_ack_d = (state_q == I_WAIT);
          d_ack_d = (state_q == D_WAIT);
          if (state_q == I_WAIT) begin
            i_data_d = data_in_BUS;
          end else if (!we_q) begin
            d_rdata_d = data_in_BUS;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          i_ack_d = (state_q == I_WAIT);
          d_ack_d = (state_q == D_WAIT);
          if (state_q == I_WAIT) begin
            i_data_d = '0;
          end else if (!we_q) begin
            d_rdata_d = '0;
          end
        end else begin
          rd_d   = ~we_q;
          wr_d   = we_q;
          aout_d = addr_q;
          dout_d = we_q ? wdata_q : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      aout_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      aout_q    <= aout_d;
      dout_q    <= dout_d;
    end
  end

  assign i_data       = i_data_q;
  assign d_rdata      = d_rdata_q;
  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign bus_err      = err_q;
  assign bus_read     = rd_q;
  assign bus_write    = wr_q;
  assign address_out  = aout_q;
  assign data_out_BUS = dout_q;
  assign busy         = (state_q != IDLE);

endmodule
